// File: rtl/rgb2ycrcb_ctrl.sv
// Sequencing controller around the rgb2ycrcb converter: feeds one frame of RGB pixels,
// catches the converted results in a small FIFO and uses credits so the converter never overruns it.
`timescale 1ns/1ps
module rgb2ycrcb_ctrl #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int LATENCY    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [23:0] s_data,
   output logic        cc_enable,
   output logic [23:0] cc_data_in,
   input  logic [23:0] cc_data_out,
   input  logic        cc_enable_out,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [23:0] m_data,
   output logic        m_last
);

   localparam int TOTAL = IMG_W * IMG_H;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);
   localparam int IFW   = $clog2(LATENCY + 2);
   localparam int SW    = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   in_cnt;
   logic [CW-1:0]   out_cnt;
   logic [IFW-1:0]  in_flight;
   logic [FCW-1:0]  fifo_count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [23:0]     mem [FIFO_DEPTH];
   logic [SW-1:0]   reserved;
   logic            push;
   logic            pop;
   logic            issue;
   logic            credit_ok;
   logic            last_issue;
   logic            last_pop;
   logic            done_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Every pixel inside the converter already owns a FIFO slot; a pop this cycle frees one early.
   assign push       = cc_enable_out;
   assign m_valid    = (fifo_count != '0);
   assign pop        = m_valid & m_ready;
   assign reserved   = SW'(in_flight) + SW'(fifo_count) - SW'(pop);
   assign credit_ok  = (reserved < SW'(FIFO_DEPTH));
   assign issue      = s_valid & s_ready;
   assign cc_enable  = issue;
   assign cc_data_in = s_data;
   assign last_issue = issue && (in_cnt == CW'(TOTAL - 1));
   assign last_pop   = (state == DRAIN) && pop && (out_cnt == CW'(TOTAL - 1));
   assign m_last     = m_valid && (out_cnt == CW'(TOTAL - 1));
   assign m_data     = m_valid ? mem[rd_ptr] : '0;
   assign done       = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            s_ready = credit_ok;
            if (last_issue) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (last_pop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame counters restart on an accepted start; done trails the final handshake by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt  <= '0;
         out_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last_pop;
         if (state == IDLE && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (issue) in_cnt <= in_cnt + CW'(1);
            if (pop)   out_cnt <= out_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight <= '0;
      end else begin
         case ({issue, push})
            2'b10:   in_flight <= in_flight + IFW'(1);
            2'b01:   in_flight <= in_flight - IFW'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + FCW'(1);
            2'b01:   fifo_count <= fifo_count - FCW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset: m_data is masked until an entry is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cc_data_out;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_count == FCW'(FIFO_DEPTH)));
   a_no_stray_result: assert property (@(posedge clk) disable iff (rst)
      !(push && state == IDLE));

endmodule

// File: tb/tb_rgb2ycrcb_ctrl.sv
// Scoreboard bench for rgb2ycrcb_ctrl with a behavioural 3-cycle converter model attached.
`timescale 1ns/1ps
module tb_rgb2ycrcb_ctrl;

   localparam int TOTAL = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [23:0] s_data = '0;
   logic        cc_enable;
   logic [23:0] cc_data_in;
   logic [23:0] cc_data_out;
   logic        cc_enable_out;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [23:0] m_data;
   logic        m_last;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int issued = 0;
   int pop_cnt = 0;
   int done_cnt = 0;
   int first_issue_cyc = 0;
   bit seen_valid = 1'b0;
   bit check_latency = 1'b0;
   bit rand_ready = 1'b0;
   bit ready_level = 1'b1;
   bit last_pop_prev = 1'b0;
   bit hold_prev = 1'b0;
   logic [23:0] held_data = '0;
   logic        held_last = 1'b0;
   logic [24:0] exp_q[$];

   logic [2:0]  pipe_v;
   logic [23:0] pipe_d [3];

   rgb2ycrcb_ctrl #(
      .IMG_W(4), .IMG_H(2), .LATENCY(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .cc_enable(cc_enable), .cc_data_in(cc_data_in),
      .cc_data_out(cc_data_out), .cc_enable_out(cc_enable_out),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Full-range BT.601 in 16-bit fixed point, rounded and clamped.
   function automatic logic [23:0] convert(input logic [23:0] rgb);
      int r, g, b, y, cb, cr;
      r  = int'(rgb[7:0]);
      g  = int'(rgb[15:8]);
      b  = int'(rgb[23:16]);
      y  = (19595 * r + 38470 * g + 7471 * b + 32768) >>> 16;
      cb = 128 + ((-11059 * r - 21709 * g + 32768 * b + 32768) >>> 16);
      cr = 128 + ((32768 * r - 27439 * g - 5329 * b + 32768) >>> 16);
      if (y > 255) y = 255;
      if (cb > 255) cb = 255;
      if (cb < 0) cb = 0;
      if (cr > 255) cr = 255;
      if (cr < 0) cr = 0;
      return {cr[7:0], cb[7:0], y[7:0]};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
         for (int i = 0; i < 3; i++) pipe_d[i] <= '0;
      end else begin
         pipe_v    <= {pipe_v[1:0], cc_enable};
         pipe_d[0] <= convert(cc_data_in);
         pipe_d[1] <= pipe_d[0];
         pipe_d[2] <= pipe_d[1];
      end
   end
   assign cc_enable_out = pipe_v[2];
   assign cc_data_out   = pipe_d[2];

   always @(posedge clk) begin
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every handshake and polices done and output stability.
   always @(negedge clk) begin
      if (rst) begin
         last_pop_prev = 1'b0;
         hold_prev     = 1'b0;
      end else begin
         if (last_pop_prev) begin
            check("done_after_last", 32'(done), 32'd1);
            check("busy_low_at_done", 32'(busy), 32'd0);
         end else if (done) begin
            check("spurious_done", 32'(done), 32'd0);
         end
         if (done) done_cnt++;
         if (hold_prev) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(held_data));
            check("hold_last", 32'(m_last), 32'(held_last));
         end
         if (m_valid && !seen_valid) begin
            seen_valid = 1'b1;
            if (check_latency) check("first_out_latency", 32'(cyc - first_issue_cyc), 32'd4);
         end
         if (m_valid && m_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got %0h expected none", m_data);
            end else begin
               logic [24:0] e;
               e = exp_q.pop_front();
               check("out_data", 32'(m_data), 32'(e[23:0]));
               check("out_last", 32'(m_last), 32'(e[24]));
            end
         end
         last_pop_prev = m_valid && m_ready && m_last;
         hold_prev     = m_valid && !m_ready;
         held_data     = m_data;
         held_last     = m_last;
      end
   end

   task automatic start_frame();
      @(posedge clk);
      #1;
      start      = 1'b1;
      issued     = 0;
      pop_cnt    = 0;
      seen_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // kind 0: grey ramp R=G=B=index; kind 1: pure red.
   task automatic apply_stimulus(input int kind, input int n, input bit sparse, input bit start_mid);
      for (int i = 0; i < n; i++) begin
         logic [7:0] k;
         bit accepted;
         k = 8'(i);
         if (sparse) begin
            repeat ($urandom_range(0, 2)) begin
               s_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_valid  = 1'b1;
         s_data   = (kind == 0) ? {k, k, k} : 24'h0000FF;
         accepted = 1'b0;
         for (int w = 0; w < 200 && !accepted; w++) begin
            @(negedge clk);
            if (s_ready) begin
               accepted = 1'b1;
               if (issued == 0) first_issue_cyc = cyc;
               issued++;
               exp_q.push_back({(i == TOTAL - 1),
                                (kind == 0) ? {8'd128, 8'd128, k} : {8'd255, 8'd85, 8'd76}});
            end
            @(posedge clk);
            #1;
            start = (start_mid && i == 2 && accepted);
         end
         if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no s_ready expected pixel %0d accepted", i);
            s_valid = 1'b0;
            return;
         end
      end
      s_valid = 1'b0;
      start   = 1'b0;
      if (start_mid) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done(input int exp_done_before);
      bit seen;
      seen = 1'b0;
      for (int w = 0; w < 300 && !seen; w++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done expected done pulse");
      end
      @(posedge clk);
      #1;
      check("done_count", 32'(done_cnt), 32'(exp_done_before + 1));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("frame_out_count", 32'(pop_cnt), 32'(TOTAL));
   endtask

   task automatic check_output(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      check({tag, "_cc_enable"}, 32'(cc_enable), 32'd0);
      check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_m_last"}, 32'(m_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_m_data"}, 32'(m_data), 32'd0);
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] single frame, no stalls");
      ready_level   = 1'b1;
      check_latency = 1'b1;
      d0 = done_cnt;
      start_frame();
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      check("s_ready_after_start", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      apply_stimulus(0, TOTAL, 1'b0, 1'b0);
      wait_done(d0);
      check_latency = 1'b0;

      $display("[TB] downstream stall");
      ready_level = 1'b0;
      d0 = done_cnt;
      start_frame();
      fork
         apply_stimulus(0, TOTAL, 1'b0, 1'b0);
         begin
            repeat (15) @(negedge clk);
            check("stall_accepted", 32'(issued), 32'd4);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            ready_level = 1'b1;
         end
      join
      wait_done(d0);

      $display("[TB] sparse input, random ready");
      rand_ready = 1'b1;
      d0 = done_cnt;
      start_frame();
      apply_stimulus(1, TOTAL, 1'b1, 1'b0);
      wait_done(d0);
      rand_ready = 1'b0;

      $display("[TB] start while busy");
      d0 = done_cnt;
      start_frame();
      apply_stimulus(0, TOTAL, 1'b0, 1'b1);
      wait_done(d0);
      repeat (10) @(posedge clk);
      #1;
      check("no_restart_after_ignored_start", 32'(busy), 32'd0);
      check("single_done_after_ignored_start", 32'(done_cnt), 32'(d0 + 1));

      $display("[TB] reset mid-frame");
      d0 = done_cnt;
      start_frame();
      apply_stimulus(0, 3, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_output("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("no_done_after_abort", 32'(done_cnt), 32'(d0));
      check("no_stale_output", 32'(m_valid), 32'd0);
      start_frame();
      apply_stimulus(0, TOTAL, 1'b0, 1'b0);
      wait_done(d0);

      $display("[TB] back-to-back frames");
      d0 = done_cnt;
      start_frame();
      apply_stimulus(0, TOTAL, 1'b0, 1'b0);
      begin
         bit seen;
         seen = 1'b0;
         for (int w = 0; w < 300 && !seen; w++) begin
            @(negedge clk);
            seen = done;
         end
         if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL b2b_done_timeout: got no done expected done pulse");
         end
      end
      start_frame();
      check("b2b_busy", 32'(busy), 32'd1);
      apply_stimulus(0, TOTAL, 1'b0, 1'b0);
      wait_done(d0 + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/rgb2ycrcb_ctrl.md
# rgb2ycrcb_ctrl

Sequencing controller for the `rgb2ycrcb` colour-conversion stage. It accepts one frame of raster-order RGB pixels over a valid/ready stream and drives the converter's `enable`/`data_in`. It captures the converter's `data_out` on `enable_out` into a small output FIFO and presents YCbCr pixels downstream over valid/ready with frame-end marking. A credit counter adds backpressure to the converter, which has no stall input, so no converted pixel is ever dropped.

## Interface
Parameters:
- `IMG_W`, 640, pixels per line (≥1).
- `IMG_H`, 480, lines per frame (≥1).
- `LATENCY`, 3, converter `enable` → `enable_out` latency in cycles.
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ `LATENCY`+1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. The same `rst` drives the attached `rgb2ycrcb`.
- `start`  in  1  single-cycle pulse that begins a frame. Honoured only in IDLE.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `s_valid`  in  1  upstream pixel valid.
- `s_ready`  out  1  upstream ready.
- `s_data`  in  24  {B[23:16], G[15:8], R[7:0]}.
- `cc_enable`  out  1  to converter `enable`.
- `cc_data_in`  out  24  to converter `data_in`.
- `cc_data_out`  in  24  from converter, {Cr, Cb, Y}.
- `cc_enable_out`  in  1  from converter `enable_out`.
- `m_valid`  out  1  downstream pixel valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  24  {Cr[23:16], Cb[15:8], Y[7:0]}.
- `m_last`  out  1  high with `m_valid` on the final pixel of the frame.

## Operation
- Constant: `TOTAL = IMG_W*IMG_H`. Counters are `$clog2(TOTAL+1)` bits wide.
- FSM:
  - IDLE → RUN on `start`. Clears `in_cnt` and `out_cnt`.
  - RUN → DRAIN on the issue that makes `in_cnt` = `TOTAL`.
  - DRAIN → IDLE on the output handshake that makes `out_cnt` = `TOTAL`. `done` pulses on the following cycle.
  - `start` outside IDLE is ignored.
- Output handshake: `pop = m_valid & m_ready`.
- Credit check: `credit_ok = (in_flight + fifo_count - pop) < FIFO_DEPTH`.
- `s_ready = (state==RUN) & credit_ok`. It must not depend on `s_valid`.
- Issue: `issue = s_valid & s_ready`.
  - `cc_enable = issue`.
  - `cc_data_in = s_data` (combinational pass-through).
  - `in_cnt` increments on each issue.
- `in_flight`:
  - +1 on `issue`, −1 on `cc_enable_out`.
  - Simultaneous +1 and −1 leaves it unchanged.
  - Range 0..`LATENCY`.
- FIFO:
  - Push `cc_data_out` when `cc_enable_out` is high. The credit check guarantees space; pushing while full is an assertion failure.
  - First-word-fall-through: `m_valid = (fifo_count != 0)`, `m_data` = head entry.
  - Simultaneous push and pop keeps the count and is legal at count 0 only if the push lands the following cycle. An empty FIFO never bypasses.
  - Head pointer wraps modulo `FIFO_DEPTH`.
- `out_cnt` increments on `pop`. `m_last = m_valid & (out_cnt == TOTAL-1)`.
- `cc_enable_out` arriving in IDLE (stray) is pushed anyway and flagged by an assertion.
- Reset mid-frame aborts the frame. Controller and converter both clear, and no partial-frame `done` is generated.

## Timing
- Reset values: `s_ready`=0, `cc_enable`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0, `m_data`=0. All counters are 0 and state is IDLE.
- `start` at cycle 0 → `busy` and `s_ready` high at cycle 1.
- Pixel accepted at cycle t:
  - Converter result is pushed at t+`LATENCY`.
  - `m_valid` appears at t+`LATENCY`+1.
  - Minimum in→out latency is 4 cycles.
- Steady throughput is 1 pixel/cycle when `m_ready` is held high and `FIFO_DEPTH` ≥ `LATENCY`+1.
- With `m_ready` held low, at most `FIFO_DEPTH` pixels are accepted before `s_ready` drops. `s_ready` reasserts the cycle `pop` occurs.
- Once `m_valid` is asserted, `m_data` and `m_last` stay stable until `pop`.
- `done` asserts one cycle after the final `pop`, and `busy` falls in that same cycle.

## Test plan
- **Single frame, no stalls.** `IMG_W`=4, `IMG_H`=2; `start`; 8 pixels back-to-back with R=G=B=k for k=0..7; `m_ready`=1.
  - Expect 8 outputs with Y=k, Cb=Cr=128, in order.
  - `m_last` only on the 8th output; `done` one cycle later.
  - First `m_valid` exactly 4 cycles after the first issue.
- **Downstream stall.** `m_ready`=0 while 8 pixels are offered.
  - Exactly 4 accepted, then `s_ready`=0 with no FIFO overflow.
  - Raise `m_ready` → remaining pixels flow; all 8 are output in order.
- **Sparse input.** `s_valid` toggled randomly; `m_ready` toggled randomly; pixel (R,G,B)=(255,0,0).
  - Every output is {Cr=255, Cb=85, Y=76}.
  - Output count equals `TOTAL`; no duplicates.
- **Start while busy.** `start` pulsed mid-RUN and mid-DRAIN.
  - Ignored; frame completes with exactly one `done`.
- **Reset mid-frame.** `rst` asserted after 3 issues.
  - All outputs go to reset values immediately.
  - New `start` runs a full frame correctly with no stale output.
- **Back-to-back frames.** `start` on the cycle after `done`.
  - Second frame runs identically; `out_cnt` restarts at 0.
